// File: rtl/sipu_controller_param_if.sv
// rtl/sipu_controller_param_if.sv - start/busy handshake and memory/unit control bundle of the SIPU sequencer
interface sipu_ctrl_if #(
   parameter int AW = 32
);
   logic          start;
   logic          dither_en;
   logic          busy;
   logic          en_in_mem;
   logic [AW-1:0] in_mem_addr;
   logic          en_gray;
   logic          mux_sel;
   logic          en_out_mem;
   logic          out_mem_read;
   logic          out_mem_write;
   logic [AW-1:0] out_mem_addr;
   logic          en_err_dif;
   logic [2:0]    err_dif_addr;
   logic          done;

   modport master (
      input  start, dither_en,
      output busy, en_in_mem, in_mem_addr, en_gray, mux_sel, en_out_mem,
             out_mem_read, out_mem_write, out_mem_addr, en_err_dif, err_dif_addr, done
   );

   modport slave (
      output start, dither_en,
      input  busy, en_in_mem, in_mem_addr, en_gray, mux_sel, en_out_mem,
             out_mem_read, out_mem_write, out_mem_addr, en_err_dif, err_dif_addr, done
   );
endinterface

// File: rtl/sipu_controller_param.sv
// rtl/sipu_controller_param.sv - two-pass image sequencer: grayscale pass then optional Floyd-Steinberg pass
module sipu_controller_param #(
   parameter int            IMG_W    = 8,
   parameter int            IMG_H    = 8,
   parameter int            AW       = 32,
   parameter logic [AW-1:0] IN_BASE  = '0,
   parameter logic [AW-1:0] OUT_BASE = '0
) (
   input logic        clk,
   input logic        rst,
   sipu_ctrl_if.master bus
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [AW-1:0] W_A    = AW'(IMG_W);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_IN   = 4'd1;
   localparam logic [3:0] S_GRAY = 4'd2;
   localparam logic [3:0] S_WB   = 4'd3;
   localparam logic [3:0] S_BR1  = 4'd4;
   localparam logic [3:0] S_FSR  = 4'd5;
   localparam logic [3:0] S_ERR  = 4'd6;
   localparam logic [3:0] S_FSW  = 4'd7;
   localparam logic [3:0] S_BR2  = 4'd8;
   localparam logic [3:0] S_DONE = 4'd9;

   logic [3:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [AW-1:0] row_q, row_d;   // y*IMG_W, kept incrementally so no multiplier is needed
   logic [2:0]    slot_q, slot_d;
   logic          dith_q, dith_d;

   logic          last_x, last_y, last_px;
   logic [4:1]    vld;
   logic          nxt_ok;
   logic [2:0]    nxt_slot;
   logic [AW-1:0] pix, slot_off;
   logic [XW-1:0] adv_x;
   logic [YW-1:0] adv_y;
   logic [AW-1:0] adv_row;

   assign last_x  = (x_q == X_LAST);
   assign last_y  = (y_q == Y_LAST);
   assign last_px = last_x && last_y;
   assign pix     = row_q + AW'(x_q);

   // Neighbour slots that fall inside the image; slot 0 is the pixel itself and always valid.
   assign vld[1] = !last_x;
   assign vld[2] = (x_q != '0) && !last_y;
   assign vld[3] = !last_y;
   assign vld[4] = !last_x && !last_y;

   // Lowest valid slot above the current one; nxt_ok=0 means the slot walk is finished.
   always_comb begin
      nxt_ok   = 1'b0;
      nxt_slot = 3'd0;
      for (int s = 4; s >= 1; s--) begin
         if (vld[s] && (3'(s) > slot_q)) begin
            nxt_ok   = 1'b1;
            nxt_slot = 3'(s);
         end
      end
   end

   // Pixel offset of the current slot relative to the image origin.
   always_comb begin
      case (slot_q)
         3'd1:    slot_off = pix + AW'(1);
         3'd2:    slot_off = pix + W_A - AW'(1);
         3'd3:    slot_off = pix + W_A;
         3'd4:    slot_off = pix + W_A + AW'(1);
         default: slot_off = pix;
      endcase
   end

   // Raster-order step to the next pixel.
   always_comb begin
      adv_x   = x_q + XW'(1);
      adv_y   = y_q;
      adv_row = row_q;
      if (last_x) begin
         adv_x   = '0;
         adv_y   = y_q + YW'(1);
         adv_row = row_q + W_A;
      end
   end

   // Next-state sequencing of both passes.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      row_d   = row_q;
      slot_d  = slot_q;
      dith_d  = dith_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_IN;
               x_d     = '0;
               y_d     = '0;
               row_d   = '0;
               dith_d  = bus.dither_en;
            end
         end
         S_IN:   state_d = S_GRAY;
         S_GRAY: state_d = S_WB;
         S_WB:   state_d = S_BR1;
         S_BR1: begin
            slot_d = 3'd0;
            if (last_px) begin
               x_d     = '0;
               y_d     = '0;
               row_d   = '0;
               state_d = dith_q ? S_FSR : S_DONE;
            end else begin
               x_d     = adv_x;
               y_d     = adv_y;
               row_d   = adv_row;
               state_d = S_IN;
            end
         end
         S_FSR: begin
            if (nxt_ok) slot_d = nxt_slot;
            else        state_d = S_ERR;
         end
         S_ERR: begin
            slot_d  = 3'd0;
            state_d = S_FSW;
         end
         S_FSW: begin
            if (nxt_ok) slot_d = nxt_slot;
            else        state_d = S_BR2;
         end
         S_BR2: begin
            slot_d = 3'd0;
            if (last_px) begin
               state_d = S_DONE;
            end else begin
               x_d     = adv_x;
               y_d     = adv_y;
               row_d   = adv_row;
               state_d = S_FSR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any frame immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         row_q   <= '0;
         slot_q  <= 3'd0;
         dith_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         row_q   <= row_d;
         slot_q  <= slot_d;
         dith_q  <= dith_d;
      end
   end

   // Moore output decode from state and counters.
   always_comb begin
      bus.busy          = (state_q != S_IDLE);
      bus.en_in_mem     = 1'b0;
      bus.in_mem_addr   = '0;
      bus.en_gray       = 1'b0;
      bus.mux_sel       = 1'b0;
      bus.en_out_mem    = 1'b0;
      bus.out_mem_read  = 1'b0;
      bus.out_mem_write = 1'b0;
      bus.out_mem_addr  = '0;
      bus.en_err_dif    = 1'b0;
      bus.err_dif_addr  = 3'd0;
      bus.done          = 1'b0;
      case (state_q)
         S_IN: begin
            bus.en_in_mem   = 1'b1;
            bus.in_mem_addr = IN_BASE + pix;
         end
         S_GRAY: bus.en_gray = 1'b1;
         S_WB: begin
            bus.en_out_mem    = 1'b1;
            bus.out_mem_write = 1'b1;
            bus.out_mem_addr  = OUT_BASE + pix;
         end
         S_FSR: begin
            bus.en_out_mem   = 1'b1;
            bus.out_mem_read = 1'b1;
            bus.en_err_dif   = 1'b1;
            bus.err_dif_addr = slot_q;
            bus.out_mem_addr = OUT_BASE + slot_off;
         end
         S_ERR: begin
            bus.en_err_dif   = 1'b1;
            bus.err_dif_addr = 3'd7;
         end
         S_FSW: begin
            bus.en_out_mem    = 1'b1;
            bus.out_mem_write = 1'b1;
            bus.mux_sel       = 1'b1;
            bus.out_mem_addr  = OUT_BASE + slot_off;
         end
         S_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sipu_controller_param.sv
// tb/tb_sipu_controller_param.sv - scoreboard bench for sipu_controller_param
module tb_sipu_controller_param;

   typedef struct packed {
      logic [15:0] cyc;
      logic        en_in;
      logic [31:0] in_addr;
      logic        gray;
      logic        mux;
      logic        en_out;
      logic        rd;
      logic        wr;
      logic [31:0] out_addr;
      logic        en_ed;
      logic [2:0]  ed;
      logic        done;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sipu_ctrl_if #(.AW(32)) ifa ();
   sipu_ctrl_if #(.AW(32)) ifb ();
   sipu_ctrl_if #(.AW(32)) ifc ();

   sipu_controller_param #(.IMG_W(2), .IMG_H(2), .AW(32), .IN_BASE(32'd0), .OUT_BASE(32'd0))
      u_a (.clk(clk), .rst(rst), .bus(ifa.master));
   sipu_controller_param #(.IMG_W(1), .IMG_H(1), .AW(32), .IN_BASE(32'd7), .OUT_BASE(32'd20))
      u_b (.clk(clk), .rst(rst), .bus(ifb.master));
   sipu_controller_param #(.IMG_W(3), .IMG_H(2), .AW(32), .IN_BASE(32'd50), .OUT_BASE(32'd100))
      u_c (.clk(clk), .rst(rst), .bus(ifc.master));

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   pc     = 0;
   ev_t  qa[$];
   ev_t  qb[$];
   ev_t  qc[$];
   logic [31:0] pend[$];
   logic [15:0] fca = 0, fcb = 0, fcc = 0;

   function automatic ev_t snap(input int w, input logic [15:0] c);
      ev_t e = '0;
      e.cyc = c;
      case (w)
         0: begin
            e.en_in = ifa.en_in_mem; e.in_addr = ifa.in_mem_addr; e.gray = ifa.en_gray;
            e.mux = ifa.mux_sel; e.en_out = ifa.en_out_mem; e.rd = ifa.out_mem_read;
            e.wr = ifa.out_mem_write; e.out_addr = ifa.out_mem_addr; e.en_ed = ifa.en_err_dif;
            e.ed = ifa.err_dif_addr; e.done = ifa.done;
         end
         1: begin
            e.en_in = ifb.en_in_mem; e.in_addr = ifb.in_mem_addr; e.gray = ifb.en_gray;
            e.mux = ifb.mux_sel; e.en_out = ifb.en_out_mem; e.rd = ifb.out_mem_read;
            e.wr = ifb.out_mem_write; e.out_addr = ifb.out_mem_addr; e.en_ed = ifb.en_err_dif;
            e.ed = ifb.err_dif_addr; e.done = ifb.done;
         end
         default: begin
            e.en_in = ifc.en_in_mem; e.in_addr = ifc.in_mem_addr; e.gray = ifc.en_gray;
            e.mux = ifc.mux_sel; e.en_out = ifc.en_out_mem; e.rd = ifc.out_mem_read;
            e.wr = ifc.out_mem_write; e.out_addr = ifc.out_mem_addr; e.en_ed = ifc.en_err_dif;
            e.ed = ifc.err_dif_addr; e.done = ifc.done;
         end
      endcase
      return e;
   endfunction

   function automatic int qsize(input int w);
      case (w)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   task automatic push(input int w, input ev_t e);
      e.cyc = pc[15:0];
      pc++;
      case (w)
         0:       qa.push_back(e);
         1:       qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   task automatic check(input int w, input ev_t act);
      ev_t e;
      n_cmp++;
      if (qsize(w) == 0) begin
         n_fail++;
         $display("FAIL unexpected_busy_dut%0d actual=%h required=idle", w, act);
      end else begin
         case (w)
            0:       e = qa.pop_front();
            1:       e = qb.pop_front();
            default: e = qc.pop_front();
         endcase
         if (act !== e) begin
            n_fail++;
            $display("FAIL event_dut%0d cyc=%0d actual=%h required=%h", w, e.cyc, act, e);
         end
      end
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Event builders (cycle field filled by push).
   function automatic ev_t e_in(input logic [31:0] a);
      ev_t e = '0; e.en_in = 1'b1; e.in_addr = a; return e;
   endfunction
   function automatic ev_t e_gray();
      ev_t e = '0; e.gray = 1'b1; return e;
   endfunction
   function automatic ev_t e_wb(input logic [31:0] a);
      ev_t e = '0; e.en_out = 1'b1; e.wr = 1'b1; e.out_addr = a; return e;
   endfunction
   function automatic ev_t e_fr(input logic [2:0] s, input logic [31:0] a);
      ev_t e = '0; e.en_out = 1'b1; e.rd = 1'b1; e.en_ed = 1'b1; e.ed = s; e.out_addr = a; return e;
   endfunction
   function automatic ev_t e_err();
      ev_t e = '0; e.en_ed = 1'b1; e.ed = 3'd7; return e;
   endfunction
   function automatic ev_t e_fw(input logic [31:0] a);
      ev_t e = '0; e.en_out = 1'b1; e.wr = 1'b1; e.mux = 1'b1; e.out_addr = a; return e;
   endfunction
   function automatic ev_t e_done();
      ev_t e = '0; e.done = 1'b1; return e;
   endfunction

   task automatic gray_px(input int w, input logic [31:0] ia, input logic [31:0] oa);
      push(w, e_in(ia));
      push(w, e_gray());
      push(w, e_wb(oa));
      push(w, '0);
   endtask

   task automatic fs_read(input int w, input logic [2:0] s, input logic [31:0] a);
      push(w, e_fr(s, a));
      pend.push_back(a);
   endtask

   task automatic fs_close(input int w);
      push(w, e_err());
      foreach (pend[i]) push(w, e_fw(pend[i]));
      push(w, '0);
      pend.delete();
   endtask

   task automatic start_frame(input int w, input logic d);
      @(posedge clk); #1;
      case (w)
         0:       begin ifa.start = 1'b1; ifa.dither_en = d; end
         1:       begin ifb.start = 1'b1; ifb.dither_en = d; end
         default: begin ifc.start = 1'b1; ifc.dither_en = d; end
      endcase
      @(posedge clk); #1;
      ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
   endtask

   task automatic drain(input int w, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (qsize(w) == 0) break;
         @(posedge clk);
      end
      cmp("drain", qsize(w), 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic frame_a_plain();
      pc = 0;
      for (int p = 0; p < 4; p++) gray_px(0, p, p);
      push(0, e_done());
   endtask

   // Monitor: every busy cycle of each DUT is popped and compared.
   always @(negedge clk) begin
      if (ifa.busy) begin check(0, snap(0, fca)); fca <= fca + 16'd1; end else fca <= 16'd0;
      if (ifb.busy) begin check(1, snap(1, fcb)); fcb <= fcb + 16'd1; end else fcb <= 16'd0;
      if (ifc.busy) begin check(2, snap(2, fcc)); fcc <= fcc + 16'd1; end else fcc <= 16'd0;
   end

   initial begin
      logic hit;
      ifa.start = 1'b0; ifa.dither_en = 1'b0;
      ifb.start = 1'b0; ifb.dither_en = 1'b0;
      ifc.start = 1'b0; ifc.dither_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_outs_a", 32'(snap(0, 16'd0) != '0), 0);
      cmp("reset_outs_b", 32'(snap(1, 16'd0) != '0), 0);
      cmp("reset_outs_c", 32'(snap(2, 16'd0) != '0), 0);
      cmp("reset_busy", {29'd0, ifa.busy, ifb.busy, ifc.busy}, 0);
      rst = 1'b0;

      // 2x2 gray only: done at cycle 16.
      frame_a_plain();
      start_frame(0, 1'b0);
      drain(0, 40);

      // 2x2 with dithering: done at cycle 44.
      pc = 0;
      for (int p = 0; p < 4; p++) gray_px(0, p, p);
      fs_read(0, 0, 0); fs_read(0, 1, 1); fs_read(0, 3, 2); fs_read(0, 4, 3); fs_close(0);
      fs_read(0, 0, 1); fs_read(0, 2, 2); fs_read(0, 3, 3); fs_close(0);
      fs_read(0, 0, 2); fs_read(0, 1, 3); fs_close(0);
      fs_read(0, 0, 3); fs_close(0);
      push(0, e_done());
      start_frame(0, 1'b1);
      drain(0, 80);

      // 1x1 with dithering: done at cycle 8.
      pc = 0;
      gray_px(1, 7, 20);
      fs_read(1, 0, 20); fs_close(1);
      push(1, e_done());
      start_frame(1, 1'b1);
      drain(1, 30);

      // 3x2, IN_BASE=50, OUT_BASE=100, dithering: done at cycle 70.
      pc = 0;
      for (int p = 0; p < 6; p++) gray_px(2, 50 + p, 100 + p);
      fs_read(2, 0, 100); fs_read(2, 1, 101); fs_read(2, 3, 103); fs_read(2, 4, 104); fs_close(2);
      fs_read(2, 0, 101); fs_read(2, 1, 102); fs_read(2, 2, 103); fs_read(2, 3, 104);
      fs_read(2, 4, 105); fs_close(2);
      fs_read(2, 0, 102); fs_read(2, 2, 104); fs_read(2, 3, 105); fs_close(2);
      fs_read(2, 0, 103); fs_read(2, 1, 104); fs_close(2);
      fs_read(2, 0, 104); fs_read(2, 1, 105); fs_close(2);
      fs_read(2, 0, 105); fs_close(2);
      push(2, e_done());
      start_frame(2, 1'b1);
      drain(2, 120);

      // start held through the whole frame, dither_en raised mid-frame: one plain frame only.
      frame_a_plain();
      @(posedge clk); #1;
      ifa.start = 1'b1; ifa.dither_en = 1'b0;
      repeat (5) @(posedge clk);
      #1 ifa.dither_en = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      ifa.start = 1'b0; ifa.dither_en = 1'b0;
      drain(0, 40);
      repeat (4) @(posedge clk);

      // Reset during the write-back of pixel 3.
      pc = 0;
      for (int p = 0; p < 3; p++) gray_px(0, p, p);
      push(0, e_in(3));
      push(0, e_gray());
      start_frame(0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ifa.en_out_mem && ifa.out_mem_write && ifa.out_mem_addr == 32'd3) begin
            hit = 1'b1;
            break;
         end
      end
      cmp("wb_pixel3_seen", {31'd0, hit}, 1);
      rst = 1'b1;
      #1;
      cmp("abort_outs", 32'(snap(0, 16'd0) != '0), 0);
      cmp("abort_busy", {31'd0, ifa.busy}, 0);
      cmp("abort_queue", qsize(0), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Fresh frame after the abort restarts at pixel 0.
      frame_a_plain();
      start_frame(0, 1'b0);
      drain(0, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
